cla_sum_accumulator: RTL



---
 rtl/cla_sum_accumulator.sv | 104 ++++++++++
 1 files changed

// File: rtl/cla_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : cla_sum_accumulator
// Purpose  : Accumulates N_SAMPLES 5-bit CLA sums per window and hands the
//            window total (plus overflow flag) off over a valid/ready pair.
//            Define CLA_ACC_SATURATE_EN to clamp at the maximum instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
module cla_sum_accumulator #(
  parameter int ACC_W     = 8,
  parameter int N_SAMPLES = 4,
  parameter int CNT_W     = $clog2(N_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [4:0]       in_sum,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  localparam int              c_sum_w = ACC_W + 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(N_SAMPLES - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic [ACC_W-1:0]   r_acc;
  logic [ACC_W-1:0]   w_acc_next;
  logic               r_sticky;
  logic [CNT_W-1:0]   r_count;
  logic [ACC_W:0]     w_sum;
  logic               w_carry;
  logic               w_accept;
  logic               w_drain;
  logic               w_last;

  // Handshake outputs come straight from the state register.
  assign in_ready  = (r_state == ST_ACCUM);
  assign out_valid = (r_state == ST_HOLD);

  assign w_accept = in_valid && in_ready;
  assign w_drain  = out_valid && out_ready;
  assign w_last   = (r_count == c_last);

  assign w_sum   = {1'b0, r_acc} + c_sum_w'(in_sum);
  assign w_carry = w_sum[ACC_W];

`ifdef CLA_ACC_SATURATE_EN
  // A clamped accumulator always carries on any further nonzero add, so it stays pinned.
  assign w_acc_next = w_carry ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
  assign w_acc_next = w_sum[ACC_W-1:0];
`endif

  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = ST_ACCUM;
    end else begin
      case (r_state)
        ST_ACCUM: if (w_accept && w_last) w_state_next = ST_HOLD;
        ST_HOLD:  if (out_ready)          w_state_next = ST_ACCUM;
        default:                          w_state_next = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_ACCUM;
      r_acc    <= '0;
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_next;
      if (clear || w_drain) begin
        r_acc    <= '0;
        r_sticky <= 1'b0;
        r_count  <= '0;
      end else if (w_accept) begin
        r_acc    <= w_acc_next;
        r_sticky <= r_sticky | w_carry;
        r_count  <= r_count + 1'b1;
      end
    end
  end

  // The accumulator is frozen in HOLD, so it doubles as the result register.
  assign out_sum = r_acc;
  assign out_ovf = r_sticky;
  assign count   = r_count;

endmodule
`default_nettype wire
